// File: rtl/rr_request_client_pkg.sv
// Shared definitions for the round-robin request client: queue count,
// FSM state encoding and small grant-decoding helpers.
package rr_request_client_pkg;

  localparam int NUM_QUEUES = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_QUEUES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pending_counter.sv
// One queue's pending-job counter: push adds a job, dec removes a completed
// job, saturates at all-ones, and flags dropped pushes on a full queue.
module rr_pending_counter
  import rr_request_client_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Count update; a simultaneous push and dec cancel, so a full queue being
  // drained on the same cycle never reports an overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (push && !dec) begin
        if (count == CNT_MAX) overflow <= 1'b1;
        else                  count    <= count + CNT_ONE;
      end else if (dec && !push) begin
        if (count != '0) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/rr_request_client.sv
// Client side of a round-robin arbiter: keeps per-queue pending job counts,
// raises request_queue to the arbiter, and services a granted queue for
// SERVICE_CYCLES held cycles before completing one job.
//
// Request/grant protocol: request_queue[i] is a level that stays high while
// queue i has work; the arbiter answers with a one-hot grant_in that must be
// held steady for the whole service window. Any change of grant_in during
// service abandons the job (nothing is consumed); a multi-hot grant, or a
// grant to an empty queue while idle, is reported once on grant_error.
module rr_request_client
  import rr_request_client_pkg::*;
#(
  parameter int unsigned SERVICE_CYCLES = 150000000,
  parameter int          CNT_W          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_QUEUES-1:0]       req_push,
  input  logic [NUM_QUEUES-1:0]       grant_in,
  output logic [NUM_QUEUES-1:0]       request_queue,
  output logic [NUM_QUEUES*CNT_W-1:0] pending_cnt,
  output logic [NUM_QUEUES-1:0]       job_done,
  output logic [NUM_QUEUES-1:0]       overflow,
  output logic                        grant_error,
  output logic [1:0]                  state_dbg
);

  // The service counter reaches SVC_LAST on the final SERVE edge; together
  // with the IDLE acceptance edge that makes SERVICE_CYCLES held edges.
  localparam logic [31:0] SVC_LAST = 32'(SERVICE_CYCLES - 2);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [31:0]             svc_cnt;
  logic [NUM_QUEUES-1:0]   idx_onehot;
  logic [NUM_QUEUES-1:0]   dec;
  logic [CNT_W-1:0]        cnt [NUM_QUEUES];
  logic                    grant_onehot;
  logic                    grant_multi;
  logic                    grant_nonempty;
  logic                    grant_legal;
  logic                    illegal_now;
  logic                    illegal_q;

  // Per-queue counters with their request and packed-count views.
  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
    rr_pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .push     (req_push[i]),
      .dec      (dec[i]),
      .count    (cnt[i]),
      .overflow (overflow[i])
    );
    assign pending_cnt[i*CNT_W +: CNT_W] = cnt[i];
    assign request_queue[i]              = (cnt[i] != '0);
  end

  // Grant classification and the one-cycle decrement issued from DONE.
  always_comb begin
    grant_onehot   = $onehot(grant_in);
    grant_multi    = !$onehot0(grant_in);
    grant_nonempty = ((grant_in & request_queue) != '0);
    grant_legal    = grant_onehot && grant_nonempty;
    illegal_now    = grant_multi ||
                     ((state == ST_IDLE) && grant_onehot && !grant_nonempty);
    idx_onehot     = NUM_QUEUES'(1) << idx;
    dec            = (state == ST_DONE) ? idx_onehot : '0;
  end

  assign state_dbg = state;

  // Service FSM: accept a legal grant, count held cycles, complete one job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      svc_cnt  <= '0;
      job_done <= '0;
    end else begin
      job_done <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_legal) begin
            idx     <= onehot_index(grant_in);
            svc_cnt <= '0;
            state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (grant_in == idx_onehot) begin
            svc_cnt <= svc_cnt + 32'd1;
            if (svc_cnt == SVC_LAST) begin
              state    <= ST_DONE;
              job_done <= idx_onehot;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Report an illegal grant only on the cycle the condition first appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q   <= 1'b0;
      grant_error <= 1'b0;
    end else begin
      illegal_q   <= illegal_now;
      grant_error <= illegal_now && !illegal_q;
    end
  end

endmodule

// File: tb/tb_rr_request_client.sv
// Directed bench for rr_request_client with SERVICE_CYCLES=4, CNT_W=4.
module tb_rr_request_client;

  localparam int SVC   = 4;
  localparam int CNT_W = 4;

  logic              clk;
  logic              reset;
  logic [3:0]        req_push;
  logic [3:0]        grant_in;
  logic [3:0]        request_queue;
  logic [4*CNT_W-1:0] pending_cnt;
  logic [3:0]        job_done;
  logic [3:0]        overflow;
  logic              grant_error;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CNT_W-1:0] exp_q[$];

  rr_request_client #(
    .SERVICE_CYCLES (SVC),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_push      (req_push),
    .grant_in      (grant_in),
    .request_queue (request_queue),
    .pending_cnt   (pending_cnt),
    .job_done      (job_done),
    .overflow      (overflow),
    .grant_error   (grant_error),
    .state_dbg     (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs set after this take effect at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int q);
    return 32'(pending_cnt[q*CNT_W +: CNT_W]);
  endfunction

  initial begin
    reset    = 1'b1;
    req_push = '0;
    grant_in = '0;
    #2;
    check("rst_rq",   request_queue, 0);
    check("rst_cnt",  pending_cnt,   0);
    check("rst_done", job_done,      0);
    check("rst_ovf",  overflow,      0);
    check("rst_err",  grant_error,   0);
    check("rst_state", state_dbg,    0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single job on queue 2
    req_push = 4'b0100; tick(); req_push = '0;
    check("a_cnt2", cnt_of(2), 1);
    check("a_rq", request_queue, 4'b0100);
    grant_in = 4'b0100;
    for (int k = 0; k < SVC-1; k++) begin
      tick(); check("a_no_done", job_done, 0);
    end
    tick();
    check("a_done", job_done, 4'b0100);
    check("a_cnt_in_done", cnt_of(2), 1);
    grant_in = '0;
    tick();
    check("a_done_clr", job_done, 0);
    check("a_cnt2_after", cnt_of(2), 0);
    check("a_rq_after", request_queue, 0);

    // Three back-to-back jobs on queue 0, one every SVC+1 cycles
    req_push = 4'b0001; repeat (3) tick(); req_push = '0;
    check("b_cnt0", cnt_of(0), 3);
    exp_q.push_back(4'd3); exp_q.push_back(4'd2); exp_q.push_back(4'd1);
    grant_in = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < SVC-1; k++) begin
        tick(); check("b_gap", job_done, 0);
      end
      tick();
      check("b_done", job_done, 4'b0001);
      check("b_cnt_at_done", cnt_of(0), 32'(exp_q.pop_front()));
      if (j == 2) grant_in = '0;
      tick();
      check("b_after", job_done, 0);
      check("b_err", grant_error, 0);
    end
    check("b_cnt0_end", cnt_of(0), 0);
    check("b_rq_end", request_queue, 0);

    // Saturation and overflow on queue 1
    req_push = 4'b0010; repeat (15) tick();
    check("c_cnt15", cnt_of(1), 15);
    check("c_no_ovf", overflow, 0);
    tick(); req_push = '0;
    check("c_ovf", overflow, 4'b0010);
    check("c_sat", cnt_of(1), 15);
    tick();
    check("c_ovf_clr", overflow, 0);
    grant_in = 4'b0010;
    repeat (SVC) tick();
    check("c_done", job_done, 4'b0010);
    req_push = 4'b0010; grant_in = '0;
    tick(); req_push = '0;
    check("c_cnt_same", cnt_of(1), 15);
    check("c_ovf_none", overflow, 0);

    // Grant switch mid-service aborts queue 0, queue 1 then completes
    req_push = 4'b0001; tick(); req_push = '0;
    grant_in = 4'b0001; tick(); tick();
    grant_in = 4'b0010;
    tick();
    check("d_abort", state_dbg, 0);
    check("d_abort_done", job_done, 0);
    for (int k = 0; k < SVC-1; k++) begin
      tick(); check("d_no_done", job_done, 0);
    end
    tick();
    check("d_done", job_done, 4'b0010);
    check("d_cnt0", cnt_of(0), 1);
    grant_in = '0; tick();
    check("d_cnt1", cnt_of(1), 14);

    // Illegal grants while idle
    grant_in = 4'b0011; tick();
    check("e_err1", grant_error, 1);
    check("e_idle1", state_dbg, 0);
    grant_in = '0; tick();
    check("e_err_clr", grant_error, 0);
    grant_in = 4'b1000; tick();
    check("e_err2", grant_error, 1);
    check("e_idle2", state_dbg, 0);
    tick();
    check("e_err_once", grant_error, 0);
    grant_in = '0;
    check("e_counts", pending_cnt, 16'h00e1);

    // Multi-hot grant during service
    grant_in = 4'b0010; tick();
    check("k_serve", state_dbg, 1);
    grant_in = 4'b0110; tick();
    check("k_err", grant_error, 1);
    check("k_abort", state_dbg, 0);
    grant_in = '0; tick();
    check("k_err_clr", grant_error, 0);
    check("k_cnt1", cnt_of(1), 14);

    // Reset in the third SERVE cycle
    grant_in = 4'b0001; tick(); tick(); tick();
    check("f_serve", state_dbg, 1);
    reset = 1'b1; #1;
    check("f_rst_rq",  request_queue, 0);
    check("f_rst_cnt", pending_cnt,   0);
    check("f_rst_done", job_done,     0);
    check("f_rst_ovf", overflow,      0);
    check("f_rst_err", grant_error,   0);
    check("f_rst_state", state_dbg,   0);
    tick();
    check("f_rst_hold_done", job_done, 0);
    reset = 1'b0; grant_in = '0;
    tick(); tick();
    check("f_post_done", job_done, 0);
    check("f_post_cnt", pending_cnt, 0);

    // Simultaneous pushes on all queues
    req_push = 4'b1111; tick(); req_push = '0;
    check("m_cnt", pending_cnt, 16'h1111);
    check("m_rq", request_queue, 4'b1111);
    check("m_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
